// File: rtl/sipo_pkg.sv
// Shared helpers for the serial-to-parallel receive stage.
package sipo_pkg;

   // Bit-counter width; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/sipo_hold.sv
// One-entry holding register with valid/ready handoff and sticky overrun flag.
module sipo_hold #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_done,
   input  logic             par_ready,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             drop;

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      drop    = 1'b0;
      if (word_done) begin
         if (!valid_q || par_ready) begin
            word_d  = word_in;
            valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (valid_q && par_ready) begin
         valid_d = 1'b0;
      end
      // A drop at the same edge as a clear must still leave the flag set.
      if (ovr_clr) ovr_d = 1'b0;
      if (drop)    ovr_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign par_out   = word_q;
   assign par_valid = valid_q;
   assign overrun   = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: shifter and bit counter feeding the holding stage.
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     si,
   input  logic                     si_en,
   output logic [WIDTH-1:0]         par_out,
   output logic                     par_valid,
   input  logic                     par_ready,
   output logic                     overrun,
   input  logic                     ovr_clr,
   output logic [cnt_w(WIDTH)-1:0]  bit_cnt
);

   localparam int unsigned     CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             word_done;

   always_comb begin
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      if (si_en) begin
         if (LSB_FIRST) sh_d = {si, sh_q[WIDTH-1:1]};
         else           sh_d = {sh_q[WIDTH-2:0], si};
         // Explicit wrap keeps non-power-of-two widths correct.
         if (cnt_q == LAST) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_cnt = cnt_q;

   sipo_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .word_in  (sh_d),
      .word_done(word_done),
      .par_ready(par_ready),
      .ovr_clr  (ovr_clr),
      .par_out  (par_out),
      .par_valid(par_valid),
      .overrun  (overrun)
   );

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-to-parallel receive stage that sits directly downstream of the team's parallel-in/serial-out shifter. It accepts one bit per qualified clock and assembles WIDTH bits into a word. It hands each completed word to the next stage through a one-entry holding register with a valid/ready handshake, and flags words lost to backpressure.

Parameters:
WIDTH, 4, number of bits per word (>=2)
LSB_FIRST, 1, 1 = first received bit lands in par_out[0] (matches the upstream right-shifting shifter); 0 = first received bit lands in par_out[WIDTH-1]

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
si  input  1  serial data in
si_en  input  1  bit strobe; si is sampled on a clk edge only when si_en=1
par_out  output  WIDTH  completed word (holding register)
par_valid  output  1  par_out holds an unconsumed word
par_ready  input  1  downstream accepts par_out at this edge when par_valid=1
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  clears overrun
bit_cnt  output  clog2(WIDTH)  bits collected toward the current word

Behaviour:
- Reset (rst=1 at a clk edge): shift reg=0, bit_cnt=0, par_out=0, par_valid=0, overrun=0. Reset takes priority over every other input. A reset mid-word discards the partial word.
- Shift, LSB_FIRST=1: when si_en=1, sh <= {si, sh[WIDTH-1:1]}.
- Shift, LSB_FIRST=0: when si_en=1, sh <= {sh[WIDTH-2:0], si}.
- When si_en=1, bit_cnt increments. When si_en=0, sh and bit_cnt hold.
- Completion: when si_en=1 and bit_cnt==WIDTH-1, the assembled word (including the current si) is the completed word, and bit_cnt wraps to 0 at the same edge.
- Words are contiguous across the wrap; there is no gap cycle.
- Latency: par_out and par_valid update on the same edge that samples the last bit, so they are visible one clock after that bit is presented.
- Handshake: a transfer occurs at an edge where par_valid=1 and par_ready=1. With no new completion at that edge, par_valid goes to 0 and par_out holds its value.
- par_out is stable while par_valid=1 and par_ready=0.
- Completion with par_valid=0: load par_out, set par_valid=1.
- Completion with par_valid=1 and par_ready=1: load the new word, keep par_valid=1, no overrun (back-to-back).
- Completion with par_valid=1 and par_ready=0: the new word is dropped, par_out is unchanged, and overrun is set to 1.
- overrun is sticky until ovr_clr=1. If a set and ovr_clr occur at the same edge, the set wins.
- par_ready while par_valid=0 is ignored.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package sipo_pkg: function cnt_w(WIDTH) returning the bit_cnt width, and localparam-free shared constants only. No typedefs needed.
- One sub-module is natural: sipo_hold. It holds the holding register, valid/ready, and overrun logic, with inputs word_in, word_done, par_ready, ovr_clr.
- sipo_rx keeps the shifter and bit counter.

Test Plan:
1. Reset then word: WIDTH=4, LSB_FIRST=1, rst high 2 clocks, then si=0,1,0,1 on 4 consecutive si_en=1 edges with par_ready=0 -> par_out=4'b1010, par_valid=1 one clock after the 4th bit, bit_cnt=0.
2. Gapped strobes: same bits with si_en low for 3 cycles between bits 2 and 3 -> par_out=4'b1010, bit_cnt holds at 2 during the gap.
3. Back-to-back with ready=1: stream 0,1,0,1,1,1,0,0 continuously.
   - Words 4'b1010 then 4'b0011 each appear for exactly one valid cycle at the completion edges.
   - overrun stays 0.
4. Overrun: complete 4'b1010, hold par_ready=0, then complete 4'b1111 -> par_out stays 4'b1010 and overrun=1. Next, pulse ovr_clr with no completion -> overrun=0.
5. Reset mid-operation: send 1,1, assert rst one clock, then send 0,0,0,1 -> bit_cnt=0 after reset, par_valid=0 during reset, next word=4'b1000. Also set overrun before the reset -> overrun cleared by reset.
6. MSB-first: LSB_FIRST=0, send 1,0,1,1 -> par_out=4'b1011. A simultaneous set and ovr_clr at the same edge leaves overrun=1.
